// File: rtl/spim_reg_master.sv
// spim_reg_master: SPI mode-0 master that turns two round-robin arbitrated
// 32-bit register read/write request ports into 80-bit SPI register frames.
//
// Handshake: a requester raises req_valid[i] together with its we/addr/wdata
// and holds them until req_grant[i] is seen high for one mclk cycle; the
// fields are latched at the end of that grant cycle, so they may change
// afterwards. Completion is a one-cycle rsp_valid pulse with rsp_id and
// rsp_rdata (rsp_rdata holds until the next rsp_valid). No backpressure is
// applied on the response side.
module spim_reg_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_grant,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_csn,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] CMD_WR     = 8'h2F;
  localparam logic [7:0] CMD_RD     = 8'h10;

  state_e       state_q, state_d;
  logic         en_q, en_d;          // low only in the first cycle after reset
  logic         last_q, last_d;      // index of the most recent grant
  logic         we_q, we_d;
  logic         id_q, id_d;
  logic [7:0]   cnt_q, cnt_d;        // half-period divider
  logic [6:0]   bit_q, bit_d;        // frame bit index, 79 down to 0
  logic [79:0]  shift_q, shift_d;    // outgoing frame, MSB drives MOSI
  logic [31:0]  rx_q, rx_d;          // last 32 MISO samples
  logic         csn_q, csn_d;
  logic         sck_q, sck_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [31:0]  rsp_rdata_q, rsp_rdata_d;

  logic [1:0]   grant;
  logic         sel;
  logic         sel_we;
  logic [31:0]  sel_addr;
  logic [31:0]  sel_wdata;

  // Round-robin arbitration: grant is combinational so it appears in the
  // same cycle the FSM sits in IDLE with a valid request.
  always_comb begin
    grant = 2'b00;
    if (state_q == ST_IDLE && en_q) begin
      if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
    sel       = grant[1];
    sel_we    = sel ? req_we[1]         : req_we[0];
    sel_addr  = sel ? req_addr[63:32]   : req_addr[31:0];
    sel_wdata = sel ? req_wdata[63:32]  : req_wdata[31:0];
  end

  // Next-state and datapath update for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    en_d        = 1'b1;
    last_d      = last_q;
    we_d        = we_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    csn_d       = csn_q;
    sck_d       = sck_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          we_d    = sel_we;
          id_d    = sel;
          last_d  = sel;
          shift_d = sel_we ? {CMD_WR, sel_addr, sel_wdata, 8'h00}
                           : {CMD_RD, sel_addr, 8'h00, 32'h0};
          cnt_d   = DIV_RELOAD;
          bit_d   = 7'd79;
          csn_d   = 1'b0;
          sck_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = DIV_RELOAD;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d = DIV_RELOAD;
          if (!sck_q) begin
            // Rising SCK: sample MISO on the same edge.
            sck_d = 1'b1;
            rx_d  = {rx_q[30:0], spi_miso};
          end else begin
            // Falling SCK: advance to the next bit or finish the frame.
            sck_d = 1'b0;
            if (bit_q == 7'd0) begin
              state_d = ST_HOLD;
            end else begin
              bit_d   = bit_q - 7'd1;
              shift_d = {shift_q[78:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          cnt_d       = DIV_RELOAD;
          csn_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_rdata_d = we_q ? 32'h0 : rx_q;
          state_d     = ST_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= 8'd0;
      bit_q       <= 7'd0;
      shift_q     <= '0;
      rx_q        <= '0;
      csn_q       <= 1'b1;
      sck_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      last_q      <= last_d;
      we_q        <= we_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      csn_q       <= csn_d;
      sck_q       <= sck_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_grant = grant;
  assign busy      = (state_q != ST_IDLE) | (|grant);
  assign spi_sck   = sck_q;
  assign spi_csn   = csn_q;
  assign spi_mosi  = shift_q[79];
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spim_reg_master.sv
// Directed testbench for spim_reg_master: one instance at CLK_DIV=2 for
// write/read/arbitration/reset scenarios, one at CLK_DIV=1 for a fast read.
module tb_spim_reg_master;

  // ---------------- clock / reset ----------------
  logic mclk = 1'b0;
  logic reset_n;
  always #5 mclk = ~mclk;

  // ---------------- DUT A (CLK_DIV=2) ----------------
  logic [1:0]  a_req_valid, a_req_we, a_req_grant;
  logic [63:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_id, a_busy, a_sck, a_csn, a_mosi, a_miso;
  logic [31:0] a_rsp_rdata;
  logic [2:0]  a_dbg;

  spim_reg_master #(.CLK_DIV(2)) dut_a (
    .mclk(mclk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_grant(a_req_grant), .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id),
    .rsp_rdata(a_rsp_rdata), .busy(a_busy),
    .spi_sck(a_sck), .spi_csn(a_csn), .spi_mosi(a_mosi), .spi_miso(a_miso),
    .dbg_state(a_dbg)
  );

  // ---------------- DUT B (CLK_DIV=1) ----------------
  logic [1:0]  b_req_valid, b_req_we, b_req_grant;
  logic [63:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_id, b_busy, b_sck, b_csn, b_mosi, b_miso;
  logic [31:0] b_rsp_rdata;
  logic [2:0]  b_dbg;

  spim_reg_master #(.CLK_DIV(1)) dut_b (
    .mclk(mclk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_grant(b_req_grant), .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id),
    .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .spi_sck(b_sck), .spi_csn(b_csn), .spi_mosi(b_mosi), .spi_miso(b_miso),
    .dbg_state(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];           // expected grant order
  int a_grant_id_q[$];
  int a_grant_cyc_q[$];
  int a_rsp_cnt = 0, b_rsp_cnt = 0;
  logic a_last_id = 1'b0, b_last_id = 1'b0;
  logic [31:0] a_last_rdata = '0, b_last_rdata = '0;
  int a_csn_cnt = 0, b_csn_cnt = 0;
  int a_rises = 0, b_rises = 0;
  logic [79:0] a_mosi_bits = '0, b_mosi_bits = '0;
  logic [31:0] a_slave_data = '0, b_slave_data = '0;
  int b_rise_cyc = 0, b_rise_prev = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle counter plus grant/response/csn monitors, sampled at the rising edge.
  always @(posedge mclk) begin
    cyc++;
    if (a_req_grant != 2'b00) begin
      a_grant_id_q.push_back(a_req_grant[1] ? 1 : 0);
      a_grant_cyc_q.push_back(cyc);
    end
    if (a_rsp_valid === 1'b1) begin
      a_rsp_cnt++;
      a_last_id = a_rsp_id;
      a_last_rdata = a_rsp_rdata;
    end
    if (b_rsp_valid === 1'b1) begin
      b_rsp_cnt++;
      b_last_id = b_rsp_id;
      b_last_rdata = b_rsp_rdata;
    end
    if (a_csn === 1'b0) a_csn_cnt++;
    if (b_csn === 1'b0) b_csn_cnt++;
  end

  // SPI slave models: sample MOSI on SCK rise, update MISO on SCK fall.
  always @(negedge a_csn) begin a_rises = 0; a_mosi_bits = '0; a_csn_cnt = 0; end
  always @(posedge a_sck) begin a_mosi_bits = {a_mosi_bits[78:0], a_mosi}; a_rises++; end
  always @(negedge a_sck)
    a_miso = (a_rises >= 48 && a_rises < 80) ? a_slave_data[5'(79 - a_rises)] : 1'b0;

  always @(negedge b_csn) begin b_rises = 0; b_mosi_bits = '0; b_csn_cnt = 0; end
  always @(posedge b_sck) begin
    b_mosi_bits = {b_mosi_bits[78:0], b_mosi};
    b_rises++;
    b_rise_prev = b_rise_cyc;
    b_rise_cyc = cyc;
  end
  always @(negedge b_sck)
    b_miso = (b_rises >= 48 && b_rises < 80) ? b_slave_data[5'(79 - b_rises)] : 1'b0;

  // ---------------- bounded wait tasks ----------------
  task automatic wait_a_rsp(input int n);
    int k = 0;
    while (a_rsp_cnt < n && k < 3000) begin @(negedge mclk); k++; end
    check("a_rsp_count", 80'(a_rsp_cnt), 80'(n));
  endtask

  task automatic wait_b_rsp(input int n);
    int k = 0;
    while (b_rsp_cnt < n && k < 3000) begin @(negedge mclk); k++; end
    check("b_rsp_count", 80'(b_rsp_cnt), 80'(n));
  endtask

  task automatic wait_a_idle();
    int k = 0;
    while (a_busy !== 1'b0 && k < 100) begin @(negedge mclk); k++; end
    check("a_idle", 80'(a_busy), 80'(0));
  endtask

  task automatic wait_a_grants(input int n);
    int k = 0;
    while (a_grant_id_q.size() < n && k < 3000) begin @(negedge mclk); k++; end
    check("a_grant_count", 80'(a_grant_id_q.size()), 80'(n));
  endtask

  task automatic wait_a_rises(input int n);
    int k = 0;
    while (a_rises < n && k < 1000) begin @(negedge mclk); k++; end
    check("a_rises_reached", 80'(a_rises), 80'(n));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g0;
    reset_n = 1'b0;
    a_req_valid = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0;
    a_miso = 1'b0; b_miso = 1'b0;
    repeat (3) @(negedge mclk);

    // Reset values
    check("rst_csn", 80'(a_csn), 80'(1));
    check("rst_sck", 80'(a_sck), 80'(0));
    check("rst_mosi", 80'(a_mosi), 80'(0));
    check("rst_grant", 80'(a_req_grant), 80'(0));
    check("rst_rsp_valid", 80'(a_rsp_valid), 80'(0));
    check("rst_rsp_id", 80'(a_rsp_id), 80'(0));
    check("rst_rsp_rdata", 80'(a_rsp_rdata), 80'(0));
    check("rst_busy", 80'(a_busy), 80'(0));
    check("rst_b_csn", 80'(b_csn), 80'(1));
    check("rst_b_busy", 80'(b_busy), 80'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge mclk);

    // Write from requester 0; fields scrambled the cycle after grant
    a_req_we = 2'b01;
    a_req_addr[31:0] = 32'h3000_0004;
    a_req_wdata[31:0] = 32'hA5A5_1234;
    a_req_valid = 2'b01;
    #1;
    check("wr_grant", 80'(a_req_grant), 80'(2'b01));
    check("wr_busy", 80'(a_busy), 80'(1));
    @(negedge mclk);
    a_req_valid = 2'b00;
    a_req_addr[31:0] = 32'hFFFF_FFFF;
    a_req_wdata[31:0] = 32'h0000_0000;
    check("wr_grant_pulse", 80'(a_req_grant), 80'(0));
    check("wr_csn_fall", 80'(a_csn), 80'(0));
    wait_a_rsp(1);
    check("wr_frame", a_mosi_bits, {8'h2F, 32'h3000_0004, 32'hA5A5_1234, 8'h00});
    check("wr_rises", 80'(a_rises), 80'(80));
    check("wr_csn_low", 80'(a_csn_cnt), 80'(324));
    check("wr_rsp_id", 80'(a_last_id), 80'(0));
    check("wr_rsp_rdata", 80'(a_last_rdata), 80'(0));
    wait_a_idle();

    // Read from requester 1
    a_req_we = 2'b00;
    a_req_addr[63:32] = 32'h0000_0010;
    a_slave_data = 32'hDEAD_BEEF;
    a_req_valid = 2'b10;
    #1;
    check("rd_grant", 80'(a_req_grant), 80'(2'b10));
    @(negedge mclk);
    a_req_valid = 2'b00;
    a_req_addr[63:32] = 32'h5555_5555;
    wait_a_rsp(2);
    check("rd_frame", a_mosi_bits, {8'h10, 32'h0000_0010, 8'h00, 32'h0});
    check("rd_rsp_id", 80'(a_last_id), 80'(1));
    check("rd_rsp_rdata", 80'(a_last_rdata), 80'(32'hDEAD_BEEF));
    check("rd_rdata_held", 80'(a_rsp_rdata), 80'(32'hDEAD_BEEF));
    wait_a_idle();

    // Both requesters valid: alternate starting with 0 (last grant was 1)
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    g0 = a_grant_id_q.size();
    a_req_we = 2'b11;
    a_req_addr = {32'h0000_1111, 32'h0000_2222};
    a_req_wdata = {32'h1111_0000, 32'h2222_0000};
    a_req_valid = 2'b11;
    wait_a_grants(g0 + 4);
    a_req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check("rr_order", 80'(a_grant_id_q[g0 + i]), 80'(exp_q.pop_front()));
    end
    for (int i = 1; i < 4; i++) begin
      check("rr_spacing", 80'(a_grant_cyc_q[g0 + i] - a_grant_cyc_q[g0 + i - 1]), 80'(327));
    end
    wait_a_rsp(6);
    wait_a_idle();

    // Reset in the middle of a write, at bit 40
    a_req_we = 2'b01;
    a_req_addr[31:0] = 32'h0F0F_0F0F;
    a_req_wdata[31:0] = 32'h0000_0001;
    a_req_valid = 2'b01;
    @(negedge mclk);
    a_req_valid = 2'b00;
    wait_a_rises(40);
    check("rst_pre_mosi", 80'(a_mosi), 80'(1));
    check("rst_pre_sck", 80'(a_sck), 80'(1));
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_csn", 80'(a_csn), 80'(1));
    check("midrst_sck", 80'(a_sck), 80'(0));
    check("midrst_mosi", 80'(a_mosi), 80'(0));
    check("midrst_busy", 80'(a_busy), 80'(0));
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    repeat (3) @(negedge mclk);
    check("midrst_no_rsp", 80'(a_rsp_cnt), 80'(6));

    // Normal frame after reset release
    a_req_we = 2'b10;
    a_req_addr[63:32] = 32'h1234_5678;
    a_req_wdata[63:32] = 32'hCAFE_F00D;
    a_req_valid = 2'b10;
    #1;
    check("post_grant", 80'(a_req_grant), 80'(2'b10));
    @(negedge mclk);
    a_req_valid = 2'b00;
    wait_a_rsp(7);
    check("post_frame", a_mosi_bits, {8'h2F, 32'h1234_5678, 32'hCAFE_F00D, 8'h00});
    check("post_csn_low", 80'(a_csn_cnt), 80'(324));
    check("post_rsp_id", 80'(a_last_id), 80'(1));
    check("post_rsp_rdata", 80'(a_last_rdata), 80'(0));
    wait_a_idle();

    // CLK_DIV=1 read on DUT B
    b_req_we = 2'b00;
    b_req_addr[31:0] = 32'hABCD_0000;
    b_slave_data = 32'h1357_9BDF;
    b_req_valid = 2'b01;
    #1;
    check("b_grant", 80'(b_req_grant), 80'(2'b01));
    @(negedge mclk);
    b_req_valid = 2'b00;
    wait_b_rsp(1);
    check("b_frame", b_mosi_bits, {8'h10, 32'hABCD_0000, 8'h00, 32'h0});
    check("b_rises", 80'(b_rises), 80'(80));
    check("b_csn_low", 80'(b_csn_cnt), 80'(162));
    check("b_sck_period", 80'(b_rise_cyc - b_rise_prev), 80'(2));
    check("b_rsp_id", 80'(b_last_id), 80'(0));
    check("b_rsp_rdata", 80'(b_last_rdata), 80'(32'h1357_9BDF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
